regbank_rr_arbiter: RTL and testbench

- Shares one bank of D-flip-flop data registers among N_REQ requesters.
- Each requester can do one read or one write per grant.
- A round-robin arbiter picks one requester per cycle and performs that requester's access on the bank.
- Sits between the requester blocks and the register storage, and owns both the storage and the sequencing.

---
 rtl/regbank_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_regbank_rr_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/regbank_rr_arbiter.sv
// Register bank shared by N_REQ requesters through a round-robin arbiter; one access per cycle.
// Optional REGBANK_ARB_LOCK_EN adds lock_i so a granted requester can keep the bank back-to-back.
module regbank_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int AW    = 3,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ-1:0]       we_i,
    input  logic [N_REQ*AW-1:0]    addr_i,
    input  logic [N_REQ*WIDTH-1:0] wdata_i,
`ifdef REGBANK_ARB_LOCK_EN
    input  logic [N_REQ-1:0]       lock_i,
`endif
    output logic [N_REQ-1:0]       grant_o,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   rvalid_o,
    output logic                   busy_o
);

    localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] bank_q [DEPTH];
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]    last_q, last_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    logic [N_REQ-1:0] elig_s;
    logic [PW-1:0]    idx_s;
    logic [PW-1:0]    win_s;
    logic             found_s;
    logic             lock_hold_s;
    logic             sel_we_s;
    logic [AW-1:0]    sel_addr_s;
    logic [WIDTH-1:0] sel_wdata_s;
    logic             bank_we_s;

    // Winner search: first eligible requester after last, wrapping; a held lock overrides it.
    always_comb begin
        elig_s  = req_i & ~grant_q;
        found_s = 1'b0;
        win_s   = last_q;
        idx_s   = {PW{1'b0}};
        for (int i = 1; i <= N_REQ; i++) begin
            idx_s = PW'((int'(last_q) + i) % N_REQ);
            if (!found_s && elig_s[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
`ifdef REGBANK_ARB_LOCK_EN
        // grant_q is always one-hot of last_q, so the locked requester is last_q itself.
        lock_hold_s = |(grant_q & req_i & lock_i);
`else
        lock_hold_s = 1'b0;
`endif
        if (lock_hold_s) begin
            found_s = 1'b1;
            win_s   = last_q;
        end else begin
            win_s = win_s;
        end
    end

    // Route the winner's access fields.
    always_comb begin
        sel_we_s    = we_i[win_s];
        sel_addr_s  = addr_i[int'(win_s)*AW +: AW];
        sel_wdata_s = wdata_i[int'(win_s)*WIDTH +: WIDTH];
    end

    // Next-state for grant, pointer and read port.
    always_comb begin
        if (found_s) begin
            grant_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_s;
            last_d    = win_s;
            rvalid_d  = ~sel_we_s;
            rdata_d   = sel_we_s ? rdata_q : bank_q[sel_addr_s];
            bank_we_s = sel_we_s;
        end else begin
            grant_d   = {N_REQ{1'b0}};
            last_d    = last_q;
            rvalid_d  = 1'b0;
            rdata_d   = rdata_q;
            bank_we_s = 1'b0;
        end
    end

    // Arbiter and read-port registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q  <= {N_REQ{1'b0}};
            last_q   <= PW'(N_REQ - 1);
            rdata_q  <= {WIDTH{1'b0}};
            rvalid_q <= 1'b0;
        end else begin
            grant_q  <= grant_d;
            last_q   <= last_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Register bank storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= {WIDTH{1'b0}};
            end
        end else if (bank_we_s) begin
            bank_q[sel_addr_s] <= sel_wdata_s;
        end
    end

    assign grant_o  = grant_q;
    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign busy_o   = |req_i;

endmodule

// File: tb/tb_regbank_rr_arbiter.sv
// Directed bench for regbank_rr_arbiter (N_REQ=4, AW=3, WIDTH=8); lock scenario needs REGBANK_ARB_LOCK_EN.
module tb_regbank_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_i;
    logic [3:0]  we_i;
    logic [11:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  lock_i;
    logic [3:0]  grant_o;
    logic [7:0]  rdata_o;
    logic        rvalid_o;
    logic        busy_o;

    int errors;
    int checks;

    regbank_rr_arbiter #(.N_REQ(4), .AW(3), .WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
`ifdef REGBANK_ARB_LOCK_EN
        .lock_i  (lock_i),
`endif
        .grant_o (grant_o),
        .rdata_o (rdata_o),
        .rvalid_o(rvalid_o),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic we, input logic [2:0] a, input logic [7:0] d);
        req_i[k]           = 1'b1;
        we_i[k]            = we;
        addr_i[k*3 +: 3]   = a;
        wdata_i[k*8 +: 8]  = d;
    endtask

    task automatic test_reset();
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant_o); end
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", rvalid_o); end
        checks++; if (rdata_o !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", rdata_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        rst = 1'b1;
        set_req(0, 1'b1, 3'd3, 8'h5A);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL busy_on got=%b exp=1", busy_o); end
        cyc();
        checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL pre_wr_grant got=%b exp=0001", grant_o); end
        req_i = 4'b0000;
        cyc();
        set_req(0, 1'b0, 3'd3, 8'h00);
        cyc();
        checks++; if (rdata_o !== 8'h5A || rvalid_o !== 1'b1) begin errors++; $display("FAIL pre_rd got=%h/%b exp=5a/1", rdata_o, rvalid_o); end
        set_req(0, 1'b1, 3'd7, 8'h77);
        #2 rst = 1'b0;
        #1;
        checks++; if (grant_o !== 4'b0000 || rvalid_o !== 1'b0 || rdata_o !== 8'h00) begin
            errors++; $display("FAIL midreset got=%b/%b/%h exp=0000/0/00", grant_o, rvalid_o, rdata_o); end
        cyc();
        cyc();
        checks++; if (grant_o !== 4'b0000 || rvalid_o !== 1'b0) begin errors++; $display("FAIL held_reset got=%b/%b exp=0000/0", grant_o, rvalid_o); end
        req_i = 4'b0000;
        rst = 1'b1;
        for (int a = 0; a < 8; a++) begin
            set_req(0, 1'b0, 3'(a), 8'h00);
            cyc();
            checks++; if (grant_o !== 4'b0001 || rvalid_o !== 1'b1 || rdata_o !== 8'h00) begin
                errors++; $display("FAIL clear_rd a=%0d got=%b/%b/%h exp=0001/1/00", a, grant_o, rvalid_o, rdata_o); end
            req_i = 4'b0000;
            cyc();
            checks++; if (grant_o !== 4'b0000 || rvalid_o !== 1'b0) begin
                errors++; $display("FAIL clear_idle a=%0d got=%b/%b exp=0000/0", a, grant_o, rvalid_o); end
        end
    endtask

    task automatic test_write_read();
        set_req(2, 1'b1, 3'd5, 8'hA5);
        cyc();
        checks++; if (grant_o !== 4'b0100 || rvalid_o !== 1'b0) begin errors++; $display("FAIL wr_grant got=%b/%b exp=0100/0", grant_o, rvalid_o); end
        req_i = 4'b0000;
        cyc();
        set_req(2, 1'b0, 3'd5, 8'h00);
        cyc();
        checks++; if (grant_o !== 4'b0100) begin errors++; $display("FAIL rd_grant got=%b exp=0100", grant_o); end
        checks++; if (rdata_o !== 8'hA5 || rvalid_o !== 1'b1) begin errors++; $display("FAIL rd_data got=%h/%b exp=a5/1", rdata_o, rvalid_o); end
        req_i = 4'b0000;
        cyc();
        checks++; if (rdata_o !== 8'hA5 || rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_hold got=%h/%b exp=a5/0", rdata_o, rvalid_o); end
    endtask

    task automatic test_contention();
        logic [3:0] exp_g [8];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) set_req(k, 1'b0, 3'(k), 8'h00);
        for (int c = 0; c < 8; c++) begin
            cyc();
            checks++; if (grant_o !== exp_g[c] || rvalid_o !== 1'b1) begin
                errors++; $display("FAIL contention c=%0d got=%b/%b exp=%b/1", c, grant_o, rvalid_o, exp_g[c]); end
        end
        req_i = 4'b0000;
        cyc();
    endtask

    task automatic test_fairness_wrap();
        logic [3:0] exp_g [4];
        exp_g = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        set_req(1, 1'b0, 3'd1, 8'h00);
        set_req(3, 1'b0, 3'd3, 8'h00);
        for (int c = 0; c < 4; c++) begin
            cyc();
            checks++; if (grant_o !== exp_g[c]) begin errors++; $display("FAIL wrap c=%0d got=%b exp=%b", c, grant_o, exp_g[c]); end
        end
        req_i = 4'b0000;
        cyc();
    endtask

    task automatic test_solo();
        set_req(0, 1'b1, 3'd0, 8'h11);
        cyc();
        checks++; if (grant_o !== 4'b0001) begin errors++; $display("FAIL solo_w1 got=%b exp=0001", grant_o); end
        set_req(0, 1'b1, 3'd0, 8'h22);
        cyc();
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL solo_gap1 got=%b exp=0000", grant_o); end
        cyc();
        checks++; if (grant_o !== 4'b0001 || rvalid_o !== 1'b0) begin errors++; $display("FAIL solo_w2 got=%b/%b exp=0001/0", grant_o, rvalid_o); end
        set_req(0, 1'b0, 3'd0, 8'h00);
        cyc();
        checks++; if (grant_o !== 4'b0000) begin errors++; $display("FAIL solo_gap2 got=%b exp=0000", grant_o); end
        cyc();
        checks++; if (grant_o !== 4'b0001 || rdata_o !== 8'h22 || rvalid_o !== 1'b1) begin
            errors++; $display("FAIL solo_rd got=%b/%h/%b exp=0001/22/1", grant_o, rdata_o, rvalid_o); end
        req_i = 4'b0000;
        cyc();
    endtask

    task automatic test_back_to_back();
        set_req(1, 1'b1, 3'd6, 8'h3C);
        set_req(2, 1'b0, 3'd6, 8'h00);
        cyc();
        checks++; if (grant_o !== 4'b0010 || rvalid_o !== 1'b0) begin errors++; $display("FAIL b2b_wr got=%b/%b exp=0010/0", grant_o, rvalid_o); end
        req_i[1] = 1'b0;
        cyc();
        checks++; if (grant_o !== 4'b0100 || rdata_o !== 8'h3C || rvalid_o !== 1'b1) begin
            errors++; $display("FAIL b2b_rd got=%b/%h/%b exp=0100/3c/1", grant_o, rdata_o, rvalid_o); end
        req_i = 4'b0000;
        cyc();
    endtask

`ifdef REGBANK_ARB_LOCK_EN
    task automatic test_lock();
        set_req(1, 1'b0, 3'd6, 8'h00);
        set_req(2, 1'b0, 3'd5, 8'h00);
        lock_i = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            cyc();
            checks++; if (grant_o !== 4'b0010) begin errors++; $display("FAIL lock c=%0d got=%b exp=0010", c, grant_o); end
        end
        req_i[1] = 1'b0;
        lock_i = 4'b0000;
        cyc();
        checks++; if (grant_o !== 4'b0100) begin errors++; $display("FAIL lock_release got=%b exp=0100", grant_o); end
        req_i = 4'b0000;
        cyc();
    endtask
`endif

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b0;
        req_i   = 4'b0000;
        we_i    = 4'b0000;
        addr_i  = 12'h000;
        wdata_i = 32'h0000_0000;
        lock_i  = 4'b0000;
        cyc();
        cyc();
        test_reset();
        test_write_read();
        test_contention();
        test_fairness_wrap();
        test_solo();
        test_back_to_back();
`ifdef REGBANK_ARB_LOCK_EN
        test_lock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
